// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start qualification, centre sampling, shift strobes,
// parity/stop checks and a single-word holding buffer with valid/ready handoff.
module uart_rx_sequencer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic                 shift,
  output logic                 sample_bit,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);
  localparam logic          PAR_EN   = (PARITY_EN != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                 state_q, state_d;
  logic                   rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_pend_q, perr_pend_d, ferr_pend_q, ferr_pend_d;
  logic                   load_pend_q, load_pend_d;
  logic                   shift_q, shift_d, sample_bit_q, sample_bit_d, busy_q, busy_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d, parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                   wrap;

  assign wrap = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    rxd_meta_d   = rxd;
    rxd_sync_d   = rxd_meta_q;
    prev_d       = prev_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    perr_pend_d  = perr_pend_q;
    ferr_pend_d  = ferr_pend_q;
    load_pend_d  = 1'b0;
    shift_d      = 1'b0;
    sample_bit_d = sample_bit_q;
    busy_d       = busy_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (sample_tick) begin
      prev_d = rxd_sync_q;
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      case (state_q)
        S_IDLE: if (!rxd_sync_q && prev_q) begin
          state_d = S_START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
        S_START: if (cnt_q == CNT_MID) begin
          if (!rxd_sync_q) begin
            // Restart the count here so every later wrap lands on a bit centre.
            state_d     = S_DATA;
            cnt_d       = '0;
            bit_cnt_d   = '0;
            perr_pend_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
        S_DATA: if (wrap) begin
          shift_d      = 1'b1;
          sample_bit_d = rxd_sync_q;
          shreg_d      = {rxd_sync_q, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d    = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
        S_PARITY: if (wrap) begin
          perr_pend_d = ((^shreg_q) ^ rxd_sync_q) != PAR_ODD;
          state_d     = S_STOP;
        end
        S_STOP: if (wrap) begin
          ferr_pend_d = !rxd_sync_q;
          load_pend_d = 1'b1;
          state_d     = S_IDLE;
          busy_d      = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    // The completed word waits one cycle in shreg; a full, unaccepted buffer drops it.
    if (load_pend_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shreg_q;
        parity_err_d = perr_pend_q;
        frame_err_d  = ferr_pend_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      perr_pend_q  <= 1'b0;
      ferr_pend_q  <= 1'b0;
      load_pend_q  <= 1'b0;
      shift_q      <= 1'b0;
      sample_bit_q <= 1'b0;
      busy_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rxd_meta_q   <= rxd_meta_d;
      rxd_sync_q   <= rxd_sync_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      perr_pend_q  <= perr_pend_d;
      ferr_pend_q  <= ferr_pend_d;
      load_pend_q  <= load_pend_d;
      shift_q      <= shift_d;
      sample_bit_q <= sample_bit_d;
      busy_q       <= busy_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign shift      = shift_q;
  assign sample_bit = sample_bit_q;
  assign busy       = busy_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Scoreboard bench for uart_rx_sequencer: frames are serialised tick by tick,
// expected bits/words are queued at issue time and a monitor checks DUT outputs.
module tb_uart_rx_sequencer;
  localparam int OS = 16, DB = 8, PEN = 1, PODD = 1;

  logic          sys_clk = 1'b0, rst = 1'b1, sample_tick = 1'b0, rxd = 1'b1, rx_ready = 1'b1;
  logic          shift, sample_bit, busy, rx_valid, parity_err, frame_err, overrun;
  logic [DB-1:0] rx_data;

  typedef struct packed {logic [DB-1:0] d; logic pe; logic fe;} word_t;
  word_t exp_q[$];
  logic  shq[$];
  int    checks = 0, errors = 0, exp_ovr = 0, obs_ovr = 0;
  bit    mdl_full = 1'b0, busy_seen = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_rx_sequencer #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_EN(PEN), .PARITY_ODD(PODD)) dut (
    .sys_clk(sys_clk), .rst(rst), .sample_tick(sample_tick), .rxd(rxd), .shift(shift),
    .sample_bit(sample_bit), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line value is set three clocks before each tick so the synchroniser has settled.
  task automatic ticks(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = v;
      repeat (3) @(negedge sys_clk);
      sample_tick = 1'b1;
      @(negedge sys_clk);
      sample_tick = 1'b0;
    end
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return (($countones(d) % 2) == PODD) ? 1'b0 : 1'b1;
  endfunction

  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop, input int gap);
    word_t w;
    ticks(1'b0, OS);
    for (int i = 0; i < DB; i++) begin
      shq.push_back(d[i]);
      ticks(d[i], OS);
    end
    if (PEN != 0) ticks(pbit, OS);
    w.d  = d;
    w.pe = (PEN != 0) && ((($countones(d) + pbit) % 2) != PODD);
    w.fe = (stop == 1'b0);
    if (!mdl_full) begin
      exp_q.push_back(w);
      mdl_full = !rx_ready;
    end else begin
      exp_ovr++;
    end
    ticks(stop, OS);
    ticks(1'b1, gap);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_shift"}, shift, 0);
    chk({tag, "_sample_bit"}, sample_bit, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  always @(negedge sys_clk) begin
    word_t w;
    logic  b;
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (overrun) obs_ovr++;
      if (shift) begin
        if (shq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_shift: got sample_bit=%0b expected no strobe", sample_bit);
        end else begin
          b = shq.pop_front();
          chk("shift_bit", sample_bit, b);
        end
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got rx_data=%0h expected no word", rx_data);
        end else begin
          w = exp_q.pop_front();
          chk("rx_data", rx_data, w.d);
          chk("parity_err", parity_err, w.pe);
          chk("frame_err", frame_err, w.fe);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish within 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    chk_reset_state("reset");
    rst = 1'b0;
    ticks(1'b1, 4);

    // Directed frames
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 3);
    send_frame(8'h3C, ~good_par(8'h3C), 1'b1, 3);
    send_frame(8'h00, 1'b1, 1'b0, 0);
    ticks(1'b0, 20);              // line stuck low: must not start
    chk("no_start_low_busy", busy, 0);
    ticks(1'b1, 3);
    send_frame(8'hA5, good_par(8'hA5), 1'b1, 3);

    // Short glitch on idle line
    busy_seen = 1'b0;
    ticks(1'b0, 4);
    chk("glitch_busy_mid", busy, 1);
    ticks(1'b1, 12);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_no_valid", rx_valid, 0);

    // Back-to-back with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, good_par(8'h11), 1'b1, 1);
    send_frame(8'h22, good_par(8'h22), 1'b1, 3);
    chk("ovr_hold_valid", rx_valid, 1);
    chk("ovr_hold_data", rx_data, 8'h11);
    chk("ovr_count", obs_ovr, exp_ovr);
    rx_ready = 1'b1;
    mdl_full = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Reset in the middle of the 4th data bit
    ticks(1'b0, OS);
    for (int i = 0; i < 3; i++) begin
      shq.push_back(1'b0 ^ (i == 1));
      ticks(i == 1, OS);
    end
    ticks(1'b1, 4);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    ticks(1'b1, 4);
    send_frame(8'h5A, good_par(8'h5A), 1'b1, 3);

    // Randomised frames
    for (int n = 0; n < 20; n++) begin
      logic [DB-1:0] d;
      logic          p, s;
      d = DB'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s, $urandom_range(1, 4));
    end

    repeat (20) @(negedge sys_clk);
    chk("words_drained", exp_q.size(), 0);
    chk("shifts_drained", shq.size(), 0);
    chk("overrun_total", obs_ovr, exp_ovr);
    chk("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
